pulse_sequencer: RTL

PULSE_SEQUENCER -- requirements
Module: pulse_sequencer

---
 rtl/pulse_sequencer_if.sv | 25 ++
 rtl/pulse_sequencer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/pulse_sequencer_if.sv
// Request/grant bundle between two pattern requesters and the pulse sequencer.
// The requester side drives req/pattern/rep and receives the one-cycle ack.
interface pulse_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int RPT_W = 4
);
  logic             req0;
  logic [WIDTH-1:0] pattern0;
  logic [RPT_W-1:0] rep0;
  logic             req1;
  logic [WIDTH-1:0] pattern1;
  logic [RPT_W-1:0] rep1;
  logic             ack0;
  logic             ack1;

  modport master (
    output req0, pattern0, rep0, req1, pattern1, rep1,
    input  ack0, ack1
  );

  modport slave (
    input  req0, pattern0, rep0, req1, pattern1, rep1,
    output ack0, ack1
  );
endinterface

// File: rtl/pulse_sequencer.sv
// Two-requester round-robin pulse sequencer: plays the granted pattern MSB-first
// rep+1 times back to back, then emits a one-cycle done pulse.
module pulse_sequencer #(
  parameter int WIDTH = 16,
  parameter int RPT_W = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  pulse_sequencer_if.slave    bus,
  output logic                busy,
  output logic                owner,
  output logic                pulse_out,
  output logic                done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RPT_W-1:0] rep_left_q, rep_left_d;
  logic             owner_q, owner_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             grant1;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    pat_d      = pat_q;
    cnt_d      = cnt_q;
    rep_left_d = rep_left_q;
    owner_d    = owner_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    grant1     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // On a tie the requester that was not served last time wins.
          grant1     = bus.req1 && (!bus.req0 || (owner_q == 1'b0));
          state_d    = SHIFT;
          shift_d    = grant1 ? bus.pattern1 : bus.pattern0;
          pat_d      = grant1 ? bus.pattern1 : bus.pattern0;
          rep_left_d = grant1 ? bus.rep1 : bus.rep0;
          cnt_d      = '0;
          owner_d    = grant1;
          ack1_d     = grant1;
          ack0_d     = !grant1;
        end
      end

      SHIFT: begin
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cnt_d = '0;
          if (rep_left_q != '0) begin
            // Reload in the same edge so repetitions follow with no gap.
            shift_d    = pat_q;
            rep_left_d = rep_left_q - 1'b1;
          end else begin
            shift_d = shift_q << 1;
            state_d = DONE;
          end
        end else begin
          shift_d = shift_q << 1;
          cnt_d   = cnt_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      rep_left_q <= '0;
      owner_q    <= 1'b1;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      rep_left_q <= rep_left_d;
      owner_q    <= owner_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
    end
  end

  // The held pattern is only consumed while SHIFT is active, so it needs no reset.
  always_ff @(posedge clk) begin
    pat_q <= pat_d;
  end

  assign bus.ack0  = ack0_q;
  assign bus.ack1  = ack1_q;
  assign owner     = owner_q;
  assign busy      = (state_q == SHIFT) || (state_q == DONE);
  assign done      = (state_q == DONE);
  assign pulse_out = (state_q == SHIFT) && shift_q[WIDTH-1];

endmodule
